alu_mdu: RTL and testbench

//   Parametrised WIDTH-bit ALU with iterative multiply/divide and a start/ready/done handshake.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 31 +++
 rtl/alu_mdu.sv | 213 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the alu_mdu ALU/multiply-divide unit.
// Op encodings mirror the 4-bit F field of the original combinational ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULU = 4'b1000,
    OP_DIVU = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    ITER = 2'b10,
    FIN  = 2'b11
  } state_t;

  // b_msb is the sign of the operand actually fed to the adder (after inversion for SUB)
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational logic/add/sub/SLT slice; f[2] selects B inversion plus carry-in,
// f[1:0] selects AND, OR, sum or signed less-than.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             v
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] s;

  always_comb begin
    bb = f[2] ? ~b : b;
    s  = a + bb + {{(WIDTH-1){1'b0}}, f[2]};
    v  = signed_ovf(a[WIDTH-1], bb[WIDTH-1], s[WIDTH-1]);
    case (f[1:0])
      2'b00:   y = a & bb;
      2'b01:   y = a | bb;
      2'b10:   y = s;
      2'b11:   y = {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ v};
      default: y = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// WIDTH-bit ALU with registered results and iterative unsigned multiply/divide.
// Single-cycle ops finish one cycle after accept; MULU/DIVU take WIDTH+1 cycles.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       F,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] core_y;
  logic             core_v;

  logic             go_iter;
  logic [WIDTH-1:0] one_y, one_hi;
  logic             one_z, one_v, one_dz;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .f (F[2:0]),
    .a (A),
    .b (B),
    .y (core_y),
    .v (core_v)
  );

  // Result of an op that completes in one cycle; reserved codes fall through to Y=0/Zero=1
  always_comb begin
    go_iter = 1'b0;
    one_y   = {WIDTH{1'b0}};
    one_hi  = {WIDTH{1'b0}};
    one_z   = 1'b1;
    one_v   = 1'b0;
    one_dz  = 1'b0;
    case (F)
      OP_AND, OP_OR, OP_SLT: begin
        one_y = core_y;
        one_z = (core_y == {WIDTH{1'b0}});
      end
      OP_ADD, OP_SUB: begin
        one_y = core_y;
        one_z = (core_y == {WIDTH{1'b0}});
        one_v = core_v;
      end
      OP_MULU: begin
        if (MUL_EN) go_iter = 1'b1;
        else        go_iter = 1'b0;
      end
      OP_DIVU: begin
        if (!DIV_EN) begin
          go_iter = 1'b0;
        end else if (B == {WIDTH{1'b0}}) begin
          one_y  = {WIDTH{1'b1}};
          one_hi = A;
          one_z  = 1'b0;
          one_dz = 1'b1;
        end else begin
          go_iter = 1'b1;
        end
      end
      default: go_iter = 1'b0;
    endcase
  end

  // One shift-add (MULU) or restoring-subtract (DIVU) step on the {hi,lo} pair
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and output-register update
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    y_d      = y_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, ONE, FIN: begin
        // ONE and FIN are the done cycle; a new request is accepted there too
        if (!start) begin
          state_d = IDLE;
        end else if (go_iter) begin
          state_d  = ITER;
          a_d      = A;
          b_d      = B;
          is_div_d = (F == OP_DIVU);
          acc_hi_d = {WIDTH{1'b0}};
          acc_lo_d = (F == OP_DIVU) ? A : B;
          cnt_d    = {CW{1'b0}};
        end else begin
          state_d = ONE;
          done_d  = 1'b1;
          y_d     = one_y;
          hi_d    = one_hi;
          zero_d  = one_z;
          ovf_d   = one_v;
          dbz_d   = one_dz;
        end
      end
      ITER: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          done_d  = 1'b1;
          cnt_d   = {CW{1'b0}};
          y_d     = step_lo;
          hi_d    = step_hi;
          zero_d  = (step_lo == {WIDTH{1'b0}});
          ovf_d   = is_div_q ? 1'b0 : (step_hi != {WIDTH{1'b0}});
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != ITER);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      y_q      <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign Y         = y_q;
  assign Hi        = hi_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed vectors push hand-computed results,
// negedge monitors pop and compare on every done pulse (32-bit and 8-bit instances).
module tb_alu_mdu;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_MULU = 4'b1000, C_DIVU = 4'b1010, C_RSV = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [3:0]  f;
  logic [31:0] a, b, y, hi;
  logic        ready, done, zero, ovf, dbz;

  logic        start8;
  logic [3:0]  f8;
  logic [7:0]  a8, b8, y8, hi8;
  logic        ready8, done8, zero8, ovf8, dbz8;

  int checks = 0;
  int errors = 0;

  logic [66:0] q32[$];
  logic [66:0] q8[$];

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .F(f), .A(a), .B(b),
    .ready(ready), .done(done), .Y(y), .Hi(hi), .Zero(zero), .Overflow(ovf), .DivByZero(dbz)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .F(f8), .A(a8), .B(b8),
    .ready(ready8), .done(done8), .Y(y8), .Hi(hi8), .Zero(zero8), .Overflow(ovf8), .DivByZero(dbz8)
  );

  function automatic logic [66:0] ex(input logic [31:0] ey, input logic [31:0] ehi,
                                     input logic ez, input logic ev, input logic edz);
    return {ey, ehi, ez, ev, edz};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 32-bit result monitor
  always @(negedge clk) begin
    if (done) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", {35'd0, y}, 67'h7_FFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("result32", {y, hi, zero, ovf, dbz}, q32.pop_front());
      end
    end
  end

  // 8-bit result monitor
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", {59'd0, y8}, 67'h7_FFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("result8", {24'd0, y8, 24'd0, hi8, zero8, ovf8, dbz8}, q8.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [66:0] e, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; f = op; a = va; b = vb;
    q32.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    if (lat > 1) chk("ready_busy", {66'd0, ready}, 67'd0);
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 67'(n), 67'(lat));
    chk("ready_at_done", {66'd0, ready}, 67'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; f = 4'd0; a = 32'd0; b = 32'd0;
    start8 = 1'b0; f8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {y, hi, zero, ovf, dbz, ready, done}, {64'd0, 3'b000, 2'b10});

    issue(C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, ex(32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0), 1);
    issue(C_SLT,  32'h8000_0000, 32'h7FFF_FFFF, ex(32'd1, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_SUB,  32'd5, 32'd5,                 ex(32'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1);
    issue(C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, ex(32'hF000_F000, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_OR,   32'h0F0F_0000, 32'h0000_00F0, ex(32'h0F0F_00F0, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_SUB,  32'h8000_0000, 32'd1,         ex(32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0), 1);
    issue(C_SLT,  32'd3, 32'd5,                 ex(32'd1, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_SLT,  32'd5, 32'd3,                 ex(32'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1);
    issue(C_SLT,  32'hFFFF_FFFF, 32'd0,         ex(32'd1, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_RSV,  32'h1234_5678, 32'd9,         ex(32'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1);
    issue(C_MULU, 32'hFFFF_FFFF, 32'd2,         ex(32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1, 1'b0), 33);
    issue(C_MULU, 32'h0001_0000, 32'h0001_0000, ex(32'd0, 32'd1, 1'b1, 1'b1, 1'b0), 33);
    issue(C_MULU, 32'd7, 32'd6,                 ex(32'd42, 32'd0, 1'b0, 1'b0, 1'b0), 33);
    issue(C_DIVU, 32'd100, 32'd7,               ex(32'd14, 32'd2, 1'b0, 1'b0, 1'b0), 33);
    issue(C_DIVU, 32'd5, 32'd0,                 ex(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1), 1);
    issue(C_ADD,  32'd1, 32'd2,                 ex(32'd3, 32'd0, 1'b0, 1'b0, 1'b0), 1);
    issue(C_DIVU, 32'hFFFF_FFFF, 32'd1,         ex(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0), 33);
    issue(C_DIVU, 32'd3, 32'd10,                ex(32'd0, 32'd3, 1'b1, 1'b0, 1'b0), 33);
    issue(C_DIVU, 32'd100, 32'd7,               ex(32'd14, 32'd2, 1'b0, 1'b0, 1'b0), 33);

    // MULU aborted by reset; the mid-op start must be ignored and no done may follow
    @(negedge clk);
    start = 1'b1; f = C_MULU; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    start = 1'b1; f = C_ADD; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ignored_start_busy", {66'd0, ready}, 67'd0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_reset", {y, hi, zero, ovf, dbz, ready, done}, {64'd0, 3'b000, 2'b10});
    repeat (40) @(posedge clk);

    // 8-bit instance: 0x10 * 0x10 = 0x0100
    @(negedge clk);
    start8 = 1'b1; f8 = C_MULU; a8 = 8'h10; b8 = 8'h10;
    q8.push_back(ex(32'h00, 32'h01, 1'b1, 1'b1, 1'b0));
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 1;
    while (!done8 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency8", 67'(n), 67'd9);

    repeat (3) @(posedge clk);
    chk("q32_drained", 67'(q32.size()), 67'd0);
    chk("q8_drained", 67'(q8.size()), 67'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
